matrix_seq_ctrl: RTL

Bus-master sequencer for the 4x4x16-bit matrix ALU on the shared 256-bit memory-mapped data bus. It accepts one matrix command at a time from a requester over a valid/ready handshake. For each command it performs the full ALU transaction on the bus: load both operands, write the opcode, poll status, read the result, clear the opcode. It then returns the result over a valid/ready response channel. It is the only master of the ALU address window (0x2000–0x2FFF).

---
 rtl/matrix_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_seq_ctrl.sv
// Matrix ALU bus-master sequencer: runs one full load/op/poll/read/clear
// transaction per accepted command and returns the result matrix.
module matrix_seq_ctrl #(
  parameter int          POLL_LIMIT = 16,
  parameter logic [15:0] ALU_BASE   = 16'h2000
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [15:0]  cmd_op,
  input  logic [255:0] cmd_src1,
  input  logic [255:0] cmd_src2,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic [15:0]  address,
  inout  wire  [255:0] dataBus,
  output logic         nRead,
  output logic         nWrite
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_S1, S_WR_S2, S_WR_OP,
    S_POLL, S_RD_RES, S_CLR_OP, S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    op_q, op_d;
  logic [255:0]   src1_q, src1_d;
  logic [255:0]   src2_q, src2_d;
  logic [255:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic           nrd_q, nrd_d;
  logic           nwr_q, nwr_d;
  logic           drv_q, drv_d;
  logic [255:0]   wdat_q, wdat_d;
  logic           legal;

  always_comb begin
    legal = cmd_op inside {16'h2100, 16'h2400, 16'h2500,
                           16'h2600, 16'h2700, 16'h2800};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    nrd_d   = 1'b1;
    nwr_d   = 1'b1;
    drv_d   = 1'b0;
    wdat_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          src1_d  = cmd_src1;
          src2_d  = cmd_src2;
          res_d   = '0;
          err_d   = !legal;
          state_d = legal ? S_WR_S1 : S_RESP;
        end
      end
      S_WR_S1: state_d = S_WR_S2;
      S_WR_S2: state_d = S_WR_OP;
      S_WR_OP: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        // X or Z on the status bit is treated as not ready
        if (dataBus[0] == 1'b1) begin
          state_d = S_RD_RES;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == LIMIT) begin
            err_d   = 1'b1;
            state_d = S_CLR_OP;
          end
        end
      end
      S_RD_RES: begin
        res_d   = dataBus;
        state_d = S_CLR_OP;
      end
      S_CLR_OP: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase

    // Bus signals are registered from the state being entered
    case (state_d)
      S_WR_S1: begin
        addr_d = ALU_BASE;
        nwr_d  = 1'b0;
        drv_d  = 1'b1;
        wdat_d = src1_d;
      end
      S_WR_S2: begin
        addr_d = ALU_BASE + 16'h0001;
        nwr_d  = 1'b0;
        drv_d  = 1'b1;
        wdat_d = src2_d;
      end
      S_WR_OP: begin
        addr_d = ALU_BASE + 16'h0E00;
        nwr_d  = 1'b0;
        drv_d  = 1'b1;
        wdat_d = {240'b0, op_d};
      end
      S_POLL: begin
        addr_d = ALU_BASE + 16'h0F00;
        nrd_d  = 1'b0;
      end
      S_RD_RES: begin
        addr_d = ALU_BASE + 16'h0D00;
        nrd_d  = 1'b0;
      end
      S_CLR_OP: begin
        addr_d = ALU_BASE + 16'h0E00;
        nwr_d  = 1'b0;
        drv_d  = 1'b1;
        wdat_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      drv_q   <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      drv_q   <= drv_d;
      wdat_q  <= wdat_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = res_q;
  assign rsp_err   = err_q;
  assign address   = addr_q;
  assign nRead     = nrd_q;
  assign nWrite    = nwr_q;
  assign dataBus   = drv_q ? wdat_q : {256{1'bz}};

endmodule
